display_serializer: RTL and testbench

Output-side counterpart of the input synchronizer: takes a synchronous parallel word (one segment pattern per digit) from the counter core and shifts it MSB-first to an external serial-in/parallel-out register chain (74HC595-style). The chain is driven through a shift clock and a latch strobe. A valid/ready handshake paces the core, so a word is only accepted when the previous one has been fully shifted and latched.

---
 rtl/display_pkg.sv | 20 ++
 rtl/phase_timer.sv | 44 ++++
 rtl/display_serializer.sv | 123 ++++++++++++
 tb/tb_display_serializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display types and defaults used by the synchronizer, counter core and serializer.
package display_pkg;

   localparam int unsigned DIGITS_DEF  = 6;
   localparam int unsigned SEG_W_DEF   = 8;
   localparam int unsigned CLK_DIV_DEF = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } ser_state_e;

   // Counter width able to index n distinct values, never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Restartable CLK_DIV-cycle down-counter; expire_c_o pulses in the last cycle of each timed phase.
module phase_timer #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic restart_i,
   output logic expire_c_o
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   // Armed flag keeps expire to a single cycle once a phase has run out.
   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (restart_i) begin
         cnt_d   = CNT_W'(CLK_DIV - 1);
         armed_d = 1'b1;
      end else if (armed_q) begin
         if (cnt_q == '0) begin
            armed_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   assign expire_c_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/display_serializer.sv
// Shifts a parallel segment word MSB-first into a 74HC595-style chain, then strobes its latch.
module display_serializer
   import display_pkg::*;
#(
   parameter int unsigned DIGITS  = DIGITS_DEF,
   parameter int unsigned SEG_W   = SEG_W_DEF,
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DIGITS*SEG_W-1:0] data_in,
   input  logic                    load_in,
   output logic                    ready_out,
   output logic                    ser_data_out,
   output logic                    ser_clk_out,
   output logic                    ser_latch_out,
   output logic                    done_out
);

   localparam int unsigned WIDTH  = DIGITS * SEG_W;
   localparam int unsigned BCNT_W = cnt_width(WIDTH);

   ser_state_e        state_q, state_d;
   logic [WIDTH-1:0]  sreg_q, sreg_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic              ready_q, ready_d;
   logic              sdata_q, sdata_d;
   logic              sclk_q, sclk_d;
   logic              latch_q, latch_d;
   logic              done_q, done_d;
   logic              restart_c;
   logic              expire_c;

   phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk_i      (clk),
      .rst_n_i    (reset),
      .restart_i  (restart_c),
      .expire_c_o (expire_c)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         bcnt_q  <= '0;
         ready_q <= 1'b1;
         sdata_q <= 1'b0;
         sclk_q  <= 1'b0;
         latch_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         bcnt_q  <= bcnt_d;
         ready_q <= ready_d;
         sdata_q <= sdata_d;
         sclk_q  <= sclk_d;
         latch_q <= latch_d;
         done_q  <= done_d;
      end
   end

   // Next state plus output pre-decode, so every pin comes straight off a flop.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      bcnt_d    = bcnt_q;
      restart_c = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (load_in) begin
               sreg_d    = data_in;
               bcnt_d    = '0;
               restart_c = 1'b1;
               state_d   = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (expire_c) begin
               restart_c = 1'b1;
               state_d   = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (expire_c) begin
               restart_c = 1'b1;
               if (bcnt_q == BCNT_W'(WIDTH - 1)) begin
                  state_d = LATCH;
               end else begin
                  sreg_d  = sreg_q << 1;
                  bcnt_d  = bcnt_q + 1'b1;
                  state_d = SHIFT_LO;
               end
            end
         end
         LATCH: begin
            if (expire_c) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ready_d = (state_d == IDLE);
      sclk_d  = (state_d == SHIFT_HI);
      latch_d = (state_d == LATCH);
      sdata_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? sreg_d[WIDTH-1] : 1'b0;
   end

   assign ready_out     = ready_q;
   assign ser_data_out  = sdata_q;
   assign ser_clk_out   = sclk_q;
   assign ser_latch_out = latch_q;
   assign done_out      = done_q;

endmodule

// File: tb/tb_display_serializer.sv
// Bench for display_serializer: CLK_DIV=2 and CLK_DIV=1 instances against a cycle-timing model.
module tb_display_serializer;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a, load_a, ready_a, sdata_a, sclk_a, latch_a, done_a;
   logic         rst_b, load_b, ready_b, sdata_b, sclk_b, latch_b, done_b;
   logic [W-1:0] data_a, data_b;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   display_serializer #(.DIGITS(2), .SEG_W(4), .CLK_DIV(2)) u_a (
      .clk           (clk),
      .reset         (rst_a),
      .data_in       (data_a),
      .load_in       (load_a),
      .ready_out     (ready_a),
      .ser_data_out  (sdata_a),
      .ser_clk_out   (sclk_a),
      .ser_latch_out (latch_a),
      .done_out      (done_a)
   );

   display_serializer #(.DIGITS(2), .SEG_W(4), .CLK_DIV(1)) u_b (
      .clk           (clk),
      .reset         (rst_b),
      .data_in       (data_b),
      .load_in       (load_b),
      .ready_out     (ready_b),
      .ser_data_out  (sdata_b),
      .ser_clk_out   (sclk_b),
      .ser_latch_out (latch_b),
      .done_out      (done_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Packed view {ready, data, clk, latch, done} of one instance.
   function automatic logic [4:0] outs(input int sel);
      if (sel == 0) return {ready_a, sdata_a, sclk_a, latch_a, done_a};
      return {ready_b, sdata_b, sclk_b, latch_b, done_b};
   endfunction

   function automatic int div_of(input int sel);
      return (sel == 0) ? 2 : 1;
   endfunction

   task automatic drive(input int sel, input logic ld, input logic [W-1:0] d);
      if (sel == 0) begin
         load_a = ld;
         data_a = d;
      end else begin
         load_b = ld;
         data_b = d;
      end
   endtask

   task automatic set_rst(input int sel, input logic r);
      if (sel == 0) rst_a = r;
      else          rst_b = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected pins t cycles after the accept edge, from the published timing formulas.
   function automatic logic [4:0] model(input logic [W-1:0] word, input int t, input int d);
      int       p;
      int       tot;
      logic [2:0] idx;
      logic     c;
      p   = t / d;
      tot = (2 * W + 1) * d;
      if (t >= tot) return 5'b10001;
      if (p < 2 * W) begin
         idx = 3'(W - 1 - p / 2);
         c   = ((p % 2) == 1);
         return {1'b0, word[idx], c, 1'b0, 1'b0};
      end
      return 5'b00010;
   endfunction

   task automatic send(input int sel, input logic [W-1:0] word, input int busy_at,
                       input int rst_at, input bit preloaded, input bit chain,
                       input logic [W-1:0] next_word);
      int         d;
      int         tot;
      int         rises;
      int         dones;
      int         bad;
      logic [W-1:0] got;
      logic       prev_clk;
      logic [4:0] o;
      d        = div_of(sel);
      tot      = (2 * W + 1) * d;
      rises    = 0;
      dones    = 0;
      bad      = 0;
      got      = '0;
      prev_clk = 1'b0;
      if (!preloaded) begin
         o = outs(sel);
         chk("ready_before_load", 32'(o[4]), 32'd1);
         drive(sel, 1'b1, word);
      end
      step();
      drive(sel, 1'b0, W'($urandom));
      for (int t = 0; t <= tot; t++) begin
         o = outs(sel);
         if (t == rst_at) begin
            chk("reset_mid_outputs", 32'(o), 32'(5'b10000));
            set_rst(sel, 1'b1);
            for (int i = 0; i < 2 * W * d + d + 2; i++) begin
               step();
               if (outs(sel) !== 5'b10000) bad++;
            end
            chk("reset_mid_no_activity", 32'(bad), 32'd0);
            return;
         end
         chk($sformatf("pins_dut%0d_t%0d", sel, t), 32'(o), 32'(model(word, t, d)));
         if (o[2] && !prev_clk) begin
            got = {got[W-2:0], o[3]};
            rises++;
         end
         prev_clk = o[2];
         if (o[0]) dones++;
         if (t + 1 == busy_at) drive(sel, 1'b1, ~word);
         else if (t == busy_at) drive(sel, 1'b0, W'($urandom));
         if (t + 1 == rst_at) set_rst(sel, 1'b0);
         if (t == tot && chain) drive(sel, 1'b1, next_word);
         if (t < tot) step();
      end
      chk($sformatf("word_dut%0d", sel), 32'(got), 32'(word));
      chk("rise_count", 32'(rises), 32'(W));
      chk("done_count", 32'(dones), 32'd1);
      if (!chain) begin
         step();
         o = outs(sel);
         chk("idle_after_done", 32'(o), 32'(5'b10000));
      end
   endtask

   initial begin
      logic [W-1:0] w;
      int           s;
      int           bad;
      int           ba;

      rst_a = 1'b0;
      rst_b = 1'b0;
      drive(0, 1'b0, '0);
      drive(1, 1'b0, '0);
      repeat (3) step();
      chk("reset_outs_a", 32'(outs(0)), 32'(5'b10000));
      chk("reset_outs_b", 32'(outs(1)), 32'(5'b10000));
      rst_a = 1'b1;
      rst_b = 1'b1;
      step();

      send(0, 8'hA5, -1, -1, 1'b0, 1'b0, '0);
      send(0, 8'hFF, 10, -1, 1'b0, 1'b0, '0);
      send(0, 8'h3C, -1, -1, 1'b0, 1'b1, 8'hC3);
      send(0, 8'hC3, -1, -1, 1'b1, 1'b0, '0);
      send(0, 8'h96, -1, 13, 1'b0, 1'b0, '0);
      send(0, 8'h5A, -1, -1, 1'b0, 1'b0, '0);
      send(1, 8'h81, -1, -1, 1'b0, 1'b0, '0);

      // Reset and load on the same edge: nothing may be captured.
      drive(0, 1'b1, 8'hE7);
      set_rst(0, 1'b0);
      step();
      chk("reset_beats_load", 32'(outs(0)), 32'(5'b10000));
      set_rst(0, 1'b1);
      drive(0, 1'b0, 8'h00);
      bad = 0;
      repeat (6) begin
         step();
         if (outs(0) !== 5'b10000) bad++;
      end
      chk("no_capture_after_reset_load", 32'(bad), 32'd0);

      for (int i = 0; i < 8; i++) begin
         s  = i % 2;
         w  = W'($urandom);
         ba = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (2 * W + 1) * div_of(s) - 1) : -1;
         send(s, w, ba, -1, 1'b0, 1'b0, '0);
      end

      w = W'($urandom);
      send(1, w, -1, -1, 1'b0, 1'b1, ~w);
      send(1, ~w, -1, -1, 1'b1, 1'b0, '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
